// File: rtl/mem_stage.sv
// MIPS pipeline memory-access stage: data-memory req/ack FSM, sub-word load/store
// lane handling, and the MEM/WB pipeline register feeding wb_stage.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_write_data,
    input  logic [4:0]        i_write_register,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_mem_size,
    input  logic              i_mem_unsigned,
    output logic              o_stall,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    output logic [3:0]        o_dmem_be,
    input  logic              i_dmem_ack,
    input  logic [31:0]       i_dmem_rdata,
    output logic              o_valid,
    output logic [31:0]       o_alu_result,
    output logic [31:0]       o_read_data,
    output logic [4:0]        o_write_register,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic              o_misaligned
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        stall_fsm;

    logic        is_byte;
    logic        is_half;
    logic        mem_op;
    logic        fault;
    logic        start;
    logic [1:0]  lane;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // Access decode; size 11 falls through to word handling.
    always_comb begin
        is_byte = (i_mem_size == 2'b00);
        is_half = (i_mem_size == 2'b01);
        lane    = i_alu_result[1:0];
        mem_op  = i_valid & (i_mem_read | i_mem_write);
        fault   = mem_op & ((is_half & lane[0]) | (!is_byte && !is_half && (lane != 2'b00)));
        start   = mem_op & ~fault;
    end

    always_comb begin
        if (is_byte) begin
            be_calc    = 4'b0001 << lane;
            wdata_calc = {4{i_write_data[7:0]}};
        end else if (is_half) begin
            be_calc    = 4'b0011 << lane;
            wdata_calc = {2{i_write_data[15:0]}};
        end else begin
            be_calc    = 4'b1111;
            wdata_calc = i_write_data;
        end
    end

    // Upstream holds the instruction stable until the ack cycle, so the live
    // inputs still describe the outstanding access when the data returns.
    always_comb begin
        case (lane)
            2'b00:   byte_sel = i_dmem_rdata[7:0];
            2'b01:   byte_sel = i_dmem_rdata[15:8];
            2'b10:   byte_sel = i_dmem_rdata[23:16];
            default: byte_sel = i_dmem_rdata[31:24];
        endcase
        half_sel = lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        if (is_byte)
            load_data = {{24{byte_sel[7] & ~i_mem_unsigned}}, byte_sel};
        else if (is_half)
            load_data = {{16{half_sel[15] & ~i_mem_unsigned}}, half_sel};
        else
            load_data = i_dmem_rdata;
    end

    always_comb begin
        state_next = state;
        stall_fsm  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_WAIT;
                    stall_fsm  = 1'b1;
                end
            end
            S_WAIT: begin
                stall_fsm = ~i_dmem_ack;
                if (i_dmem_ack)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        o_stall = reset & stall_fsm;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            o_dmem_req       <= 1'b0;
            o_dmem_we        <= 1'b0;
            o_dmem_addr      <= '0;
            o_dmem_wdata     <= '0;
            o_dmem_be        <= '0;
            o_valid          <= 1'b0;
            o_alu_result     <= '0;
            o_read_data      <= '0;
            o_write_register <= '0;
            o_reg_write      <= 1'b0;
            o_mem_to_reg     <= 1'b0;
            o_misaligned     <= 1'b0;
        end else begin
            state            <= state_next;
            o_misaligned     <= (state == S_IDLE) & fault;
            // Bubble by default; overridden below when an instruction retires.
            o_valid          <= 1'b0;
            o_alu_result     <= '0;
            o_read_data      <= '0;
            o_write_register <= '0;
            o_reg_write      <= 1'b0;
            o_mem_to_reg     <= 1'b0;

            if (state == S_IDLE) begin
                if (start) begin
                    o_dmem_req   <= 1'b1;
                    o_dmem_we    <= i_mem_write;
                    o_dmem_addr  <= {i_alu_result[ADDR_W-1:2], 2'b00};
                    o_dmem_wdata <= wdata_calc;
                    o_dmem_be    <= be_calc;
                end else if (i_valid && !mem_op) begin
                    o_valid          <= 1'b1;
                    o_alu_result     <= i_alu_result;
                    o_write_register <= i_write_register;
                    o_reg_write      <= i_reg_write;
                    o_mem_to_reg     <= i_mem_to_reg;
                end
            end else if (i_dmem_ack) begin
                o_dmem_req       <= 1'b0;
                o_valid          <= 1'b1;
                o_alu_result     <= i_alu_result;
                o_read_data      <= o_dmem_we ? '0 : load_data;
                o_write_register <= i_write_register;
                o_reg_write      <= i_reg_write;
                o_mem_to_reg     <= i_mem_to_reg;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed stimulus pushes expected MEM/WB
// results to a scoreboard; an independent monitor pops them when o_valid rises.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_alu_result;
    logic [31:0] i_write_data;
    logic [4:0]  i_write_register;
    logic        i_reg_write;
    logic        i_mem_to_reg;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [1:0]  i_mem_size;
    logic        i_mem_unsigned;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_valid;
    logic [31:0] o_alu_result;
    logic [31:0] o_read_data;
    logic [4:0]  o_write_register;
    logic        o_reg_write;
    logic        o_mem_to_reg;
    logic        o_misaligned;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_alu_result(i_alu_result),
        .i_write_data(i_write_data), .i_write_register(i_write_register),
        .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
        .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_valid(o_valid),
        .o_alu_result(o_alu_result), .o_read_data(o_read_data),
        .o_write_register(o_write_register), .o_reg_write(o_reg_write),
        .o_mem_to_reg(o_mem_to_reg), .o_misaligned(o_misaligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  wr;
        logic        rw;
        logic        m2r;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every retired MEM/WB entry must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && o_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 alu=0x%08h expected no pending result", o_alu_result);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
                chk({mon_e.name, "_alu"}, o_alu_result, mon_e.alu);
                chk({mon_e.name, "_rdata"}, o_read_data, mon_e.rd);
                chk({mon_e.name, "_wreg"}, {27'd0, o_write_register}, {27'd0, mon_e.wr});
                chk({mon_e.name, "_regwr"}, {31'd0, o_reg_write}, {31'd0, mon_e.rw});
                chk({mon_e.name, "_m2r"}, {31'd0, o_mem_to_reg}, {31'd0, mon_e.m2r});
            end
        end
    end

    task automatic idle_inputs();
        i_valid = 0; i_alu_result = 0; i_write_data = 0; i_write_register = 0;
        i_reg_write = 0; i_mem_to_reg = 0; i_mem_read = 0; i_mem_write = 0;
        i_mem_size = 0; i_mem_unsigned = 0;
    endtask

    task automatic set_op(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg,
                          input logic rw, input logic m2r, input logic rd, input logic wr,
                          input logic [1:0] size, input logic uns);
        i_valid = 1; i_alu_result = addr; i_write_data = wd; i_write_register = wreg;
        i_reg_write = rw; i_mem_to_reg = m2r; i_mem_read = rd; i_mem_write = wr;
        i_mem_size = size; i_mem_unsigned = uns;
    endtask

    task automatic alu_op(input string name, input logic [31:0] val, input logic [4:0] wreg);
        exp_t e;
        @(negedge clk);
        set_op(val, 32'h0, wreg, 1, 0, 0, 0, 2'b10, 0);
        e = '{name, val, 32'h0, wreg, 1'b1, 1'b0, cyc + 1};
        sb_q.push_back(e);
        #1 chk({name, "_stall"}, {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic mem_op(input string name, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] wreg, input logic rw, input logic m2r,
                          input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] rdata, input int k, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic exp_we,
                          input logic [31:0] exp_rd);
        exp_t e;
        int stalls;
        stalls = 0;
        @(negedge clk);
        set_op(addr, wd, wreg, rw, m2r, rd, wr, size, uns);
        e = '{name, addr, exp_rd, wreg, rw, m2r, cyc + k + 1};
        sb_q.push_back(e);
        #1 if (o_stall) stalls++;
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            chk({name, "_req"}, {31'd0, o_dmem_req}, 32'd1);
            if (j == 1) begin
                chk({name, "_addr"}, o_dmem_addr, {addr[31:2], 2'b00});
                chk({name, "_be"}, {28'd0, o_dmem_be}, {28'd0, exp_be});
                chk({name, "_wdata"}, o_dmem_wdata, exp_wdata);
                chk({name, "_we"}, {31'd0, o_dmem_we}, {31'd0, exp_we});
            end
            if (j == k) begin
                i_dmem_ack = 1;
                i_dmem_rdata = rdata;
            end
            #1 if (o_stall) stalls++;
        end
        @(negedge clk);
        i_dmem_ack = 0;
        i_dmem_rdata = 32'hDEAD_BEEF;
        idle_inputs();
        chk({name, "_req_drop"}, {31'd0, o_dmem_req}, 32'd0);
        chk({name, "_stall_cycles"}, stalls, k);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_req"}, {31'd0, o_dmem_req}, 32'd0);
        chk({name, "_we"}, {31'd0, o_dmem_we}, 32'd0);
        chk({name, "_addr"}, o_dmem_addr, 32'd0);
        chk({name, "_wdata"}, o_dmem_wdata, 32'd0);
        chk({name, "_be"}, {28'd0, o_dmem_be}, 32'd0);
        chk({name, "_valid"}, {31'd0, o_valid}, 32'd0);
        chk({name, "_alu"}, o_alu_result, 32'd0);
        chk({name, "_rdata"}, o_read_data, 32'd0);
        chk({name, "_wreg"}, {27'd0, o_write_register}, 32'd0);
        chk({name, "_regwr"}, {31'd0, o_reg_write}, 32'd0);
        chk({name, "_m2r"}, {31'd0, o_mem_to_reg}, 32'd0);
        chk({name, "_mis"}, {31'd0, o_misaligned}, 32'd0);
        chk({name, "_stall"}, {31'd0, o_stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0;
        i_dmem_ack = 0;
        i_dmem_rdata = 32'hDEAD_BEEF;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_all_zero("reset_init");
        reset = 1;

        alu_op("alu", 32'h0000_1234, 5'd5);
        //                addr          wd            reg  rw m2r rd wr size  uns rdata         k  be       wdata         we rd_exp
        mem_op("lb",   32'h0000_0103, 32'h0,        5'd8, 1, 1, 1, 0, 2'b00, 0, 32'h80FF_1122, 3, 4'b1000, 32'h0,        0, 32'hFFFF_FF80);
        mem_op("lhu",  32'h0000_0102, 32'h0,        5'd9, 1, 1, 1, 0, 2'b01, 1, 32'h9ABC_0000, 1, 4'b1100, 32'h0,        0, 32'h0000_9ABC);
        mem_op("lh",   32'h0000_0100, 32'h0,        5'd10, 1, 1, 1, 0, 2'b01, 0, 32'h1234_8001, 2, 4'b0011, 32'h0,       0, 32'hFFFF_8001);
        mem_op("lbu",  32'h0000_0101, 32'h0,        5'd11, 1, 1, 1, 0, 2'b00, 1, 32'h0000_F000, 1, 4'b0010, 32'h0,       0, 32'h0000_00F0);
        mem_op("lw",   32'h0000_0204, 32'h0,        5'd12, 1, 1, 1, 0, 2'b10, 0, 32'hCAFE_BABE, 1, 4'b1111, 32'h0,       0, 32'hCAFE_BABE);
        mem_op("sb",   32'h0000_0201, 32'h0000_00AB, 5'd0, 0, 0, 0, 1, 2'b00, 0, 32'h5555_5555, 1, 4'b0010, 32'hABAB_ABAB, 1, 32'h0);
        mem_op("sw",   32'h0000_0200, 32'h1122_3344, 5'd0, 0, 0, 0, 1, 2'b10, 0, 32'h5555_5555, 2, 4'b1111, 32'h1122_3344, 1, 32'h0);
        mem_op("sh",   32'h0000_0202, 32'h0000_BEEF, 5'd0, 0, 0, 0, 1, 2'b01, 0, 32'h5555_5555, 1, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0);
        mem_op("rw11", 32'h0000_0300, 32'h0BAD_F00D, 5'd0, 0, 0, 1, 1, 2'b11, 0, 32'h7777_7777, 1, 4'b1111, 32'h0BAD_F00D, 1, 32'h0);
        alu_op("alu2", 32'hFFFF_0001, 5'd31);

        // Misaligned word load, then an ALU op right behind it.
        @(negedge clk);
        set_op(32'h0000_0202, 32'h0, 5'd7, 1, 1, 1, 0, 2'b10, 0);
        #1 chk("mis_lw_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        chk("mis_lw_flag", {31'd0, o_misaligned}, 32'd1);
        chk("mis_lw_req", {31'd0, o_dmem_req}, 32'd0);
        chk("mis_lw_valid", {31'd0, o_valid}, 32'd0);
        chk("mis_lw_regwr", {31'd0, o_reg_write}, 32'd0);
        set_op(32'h0000_4321, 32'h0, 5'd3, 1, 0, 0, 0, 2'b10, 0);
        mon_e = '{"alu_after_mis", 32'h0000_4321, 32'h0, 5'd3, 1'b1, 1'b0, cyc + 1};
        sb_q.push_back(mon_e);
        #1 chk("alu_after_mis_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        chk("mis_lw_pulse_end", {31'd0, o_misaligned}, 32'd0);

        // Misaligned half load.
        @(negedge clk);
        set_op(32'h0000_0101, 32'h0, 5'd7, 1, 1, 1, 0, 2'b01, 0);
        #1 chk("mis_lh_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        chk("mis_lh_flag", {31'd0, o_misaligned}, 32'd1);
        chk("mis_lh_req", {31'd0, o_dmem_req}, 32'd0);

        // Asynchronous reset in the middle of an outstanding access.
        @(negedge clk);
        set_op(32'h0000_0300, 32'h0, 5'd4, 1, 1, 1, 0, 2'b10, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_req", {31'd0, o_dmem_req}, 32'd1);
        #2 reset = 0;
        #1 check_all_zero("reset_midwait");
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(negedge clk);
        i_dmem_ack = 1;
        i_dmem_rdata = 32'h1234_5678;
        #1 chk("stray_ack_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        i_dmem_ack = 0;
        chk("stray_ack_req", {31'd0, o_dmem_req}, 32'd0);
        chk("stray_ack_valid", {31'd0, o_valid}, 32'd0);

        alu_op("alu_post_reset", 32'h0000_00AA, 5'd1);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM register and `wb_stage`. It does three things:
- runs loads and stores against a data memory with a req/ack handshake of variable latency;
- aligns and sign- or zero-extends sub-word loads;
- holds the MEM/WB pipeline register whose outputs drive `wb_stage` directly.

It stalls upstream while a memory access is outstanding.

## Interface
- `ADDR_W`, 32, data-memory byte-address width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `i_valid`  in  1  EX/MEM holds a real instruction.
- `i_alu_result`  in  32  ALU result, also the byte address for loads and stores.
- `i_write_data`  in  32  rt value to store.
- `i_write_register`  in  5  destination register.
- `i_reg_write`, `i_mem_to_reg`, `i_mem_read`, `i_mem_write`  in  1 each  control bits.
- `i_mem_size`  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `i_mem_unsigned`  in  1  zero-extend loads (lbu/lhu).
- `o_stall`  out  1  combinational; upstream holds all inputs stable while it is high.
- `o_dmem_req`, `o_dmem_we`  out  1 each  registered memory request and write enable.
- `o_dmem_addr`  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- `o_dmem_wdata`  out  32  write data with the value replicated across byte lanes.
- `o_dmem_be`  out  4  byte enables.
- `i_dmem_ack`  in  1  one-cycle completion pulse.
- `i_dmem_rdata`  in  32  read data, valid while `i_dmem_ack` is high.
- `o_valid`, `o_alu_result[32]`, `o_read_data[32]`, `o_write_register[5]`, `o_reg_write`, `o_mem_to_reg`  out  MEM/WB register contents, fed to `wb_stage`.
- `o_misaligned`  out  1  registered one-cycle pulse on an alignment fault.

## Operation
- **Memory op:** `i_valid` and (`i_mem_read` or `i_mem_write`). If both read and write are set, write wins.
- **Alignment faults:**
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0.
  - On a fault: no bus access, no stall, `o_misaligned`=1 for one cycle, and MEM/WB loads a bubble.
- **Byte lanes (little-endian):** lane = addr[1:0].
  - Byte: be = 0001<<addr[1:0], wdata = {4{wd[7:0]}}.
  - Half: be = 0011<<addr[1:0], wdata = {2{wd[15:0]}}.
  - Word: be = 1111, wdata = wd.
- **Load extract:**
  - Byte: rdata[8*lane+7 : 8*lane].
  - Half: rdata[31:16] if addr[1]=1, else rdata[15:0].
  - Extension: sign-extend unless `i_mem_unsigned`; word loads pass through unchanged.
- **FSM, IDLE state:**
  - Aligned memory op → latch addr/we/be/wdata, `o_dmem_req`<=1, go to WAIT. `o_stall`=1 combinationally in this cycle.
  - Any other input → no state change.
- **FSM, WAIT state:**
  - `o_dmem_req` stays high with stable address/we/be/wdata.
  - `o_stall` = !`i_dmem_ack`.
  - On ack: `o_dmem_req`<=0, MEM/WB loads the instruction (loads use the extracted data, stores keep `o_read_data`=0), go to IDLE.
- **MEM/WB update, every edge:**
  - Non-memory valid instruction → pass-through with `o_read_data`=0.
  - Stall cycle, fault, or `i_valid`=0 → bubble: `o_valid`=0, `o_reg_write`=0, `o_mem_to_reg`=0, data fields 0.
- `i_dmem_ack` in IDLE is ignored.

## Timing
- **Reset:** state=IDLE, and every output register is 0: `o_dmem_*`, `o_valid`, `o_alu_result`, `o_read_data`, `o_write_register`, `o_reg_write`, `o_mem_to_reg`, `o_misaligned`. Applies immediately, including mid-WAIT; the pending access is abandoned. `o_stall` is 0 while in reset.
- **Non-memory op:** presented in cycle N → MEM/WB valid in N+1. No stall.
- **Memory op, ack after k≥1 cycles of req** (presented in IDLE at cycle N):
  - `o_dmem_req` is high in N+1 … N+k.
  - ack arrives in N+k.
  - `o_stall` is high in N … N+k-1 and low in N+k, so upstream advances at the N+k edge.
  - MEM/WB is valid in N+k+1.
  - Best case k=1: 2-cycle latency, 1 stall cycle.
- A memory op immediately following an ack-cycle advance is evaluated in IDLE in the next cycle. Throughput is at most one memory op per 2 cycles.
- **Fault:** `o_misaligned` and the bubble both appear in N+1.

## Test plan
- **Reset:** `reset`=0 asserted mid-WAIT with req high → all outputs 0 asynchronously. After release, a stray `i_dmem_ack` → no state change.
- **ALU op:** `i_alu_result`=0x0000_1234, reg 5, reg_write=1 → next cycle `o_valid`=1, `o_alu_result`=0x1234, `o_write_register`=5, `o_stall` never high.
- **lb, sign-extend:** lb at 0x103, rdata=0x80FF_1122, ack after 3 req cycles → `o_read_data`=0xFFFF_FF80; `o_stall` high exactly 3 cycles; `o_dmem_addr`=0x100, be=1000.
- **lhu:** lhu at 0x102, rdata=0x9ABC_0000, k=1 → `o_read_data`=0x0000_9ABC, total latency 2.
- **Stores:**
  - sb at 0x201 with wd=0x0000_00AB → `o_dmem_we`=1, be=0010, wdata=0xABAB_ABAB.
  - sw at 0x200 with wd=0x1122_3344 → be=1111, wdata=0x1122_3344.
  - Both → MEM/WB `o_reg_write`=0.
- **Misaligned:** lw at 0x202 → no `o_dmem_req`, `o_misaligned`=1 for one cycle, MEM/WB bubble; an ALU op in the following cycle passes normally.
